seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//   Parametrised serial bit-pattern detector with a runtime-loadable pattern.
//   Samples one serial bit per qualified clock and pulses out for one cycle when
//   the last LEN accepted bits equal the pattern. Overlapping and non-overlapping
//   match modes are selectable; matches are counted in a saturating counter.
//   Shift-register/compare successor to the fixed 9-bit hand-coded detector FSM.
// PARAMETERS
//   LEN          9             pattern length in bits, >= 2
//   CNT_W        8             match counter width, >= 1
//   DEFAULT_PAT  9'b011010101  pattern after reset, LEN bits, MSB = first bit received
// PORTS
//   clk       in   1      single clock, all state updates on posedge
//   rst       in   1      synchronous, active-high reset
//   en        in   1      in is a valid serial bit this cycle
//   in        in   1      serial data bit
//   overlap   in   1      1 = overlapping matches, 0 = non-overlapping
//   pat_wr    in   1      load pat_data as the new pattern
//   pat_data  in   LEN    new pattern, MSB = first bit received
//   cnt_clr   in   1      clear match counter
//   out       out  1      one-cycle match pulse, registered
//   match_cnt out  CNT_W  saturating match count
// BEHAVIOUR
//   Reset (rst=1 at posedge, overrides all other inputs): hist=0, fill=0,
//     pat=DEFAULT_PAT, out=0, match_cnt=0.
//   State: hist[LEN-1:0] bit history; fill 0..LEN saturating count of valid
//     history bits; pat[LEN-1:0] active pattern.
//   Accepted bit: en=1 and pat_wr=0. hist <= {hist[LEN-2:0], in};
//     fill <= min(fill+1, LEN).
//   Match: accepted bit and fill >= LEN-1 and {hist[LEN-2:0], in} == pat.
//   out: registered on the edge that samples the final pattern bit and high
//     for exactly the following cycle. out=0 in every cycle without a match,
//     including en=0 cycles.
//   overlap=1: after a match fill stays LEN; the pattern suffix counts toward
//     the next match.
//   overlap=0: after a match fill <= 0; the next match needs LEN fresh accepted
//     bits. overlap is sampled per accepted bit; a change applies immediately.
//   pat_wr=1: pat <= pat_data, fill <= 0, out <= 0. pat_wr has priority over en;
//     a bit presented in the same cycle is discarded and not shifted.
//   match_cnt: +1 per match, saturates at all-ones (no wrap).
//     cnt_clr alone -> 0. cnt_clr and match in the same cycle -> 1.
//   Reset mid-stream discards the partial history and restores DEFAULT_PAT.
//   Latency: 0 cycles from the sampling edge to out high; no backpressure.
// TESTING
//   1. Reset; en=1 every cycle; in = 0,1,1,0,1,0,1,0,1 -> out high exactly one
//      cycle after the 9th edge; match_cnt=1; out=0 in all other cycles.
//   2. Repeat test 1 with en=0 for 2 cycles between every bit -> same single
//      out pulse after the 9th accepted bit; out=0 during gap cycles.
//   3. pat_wr with pat_data=9'b101010101; stream 1,0,1,0,1,0,1,0,1,0,1,0,1.
//      overlap=1 -> pulses after bits 9, 11, 13; match_cnt=3.
//      overlap=0 -> one pulse after bit 9; match_cnt=1.
//   4. Default pattern; feed 5 correct bits; pat_wr with DEFAULT_PAT while
//      en=1 (bit dropped); feed the remaining 4 bits -> no out; match_cnt=0.
//   5. CNT_W=2; 5 matches -> match_cnt=3 (saturated). cnt_clr together with the
//      6th match -> match_cnt=1. cnt_clr alone -> match_cnt=0.
//   6. Load a custom pattern; feed 8 matching bits; rst for 1 cycle; feed the
//      9th bit -> no out. Then the default sequence from test 1 -> match; this
//      confirms pat has returned to DEFAULT_PAT.

Source files
------------

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - serial pattern detector with loadable pattern and saturating match count
module seq_detect_param #(
  parameter int             LEN         = 9,
  parameter int             CNT_W       = 8,
  parameter logic [LEN-1:0] DEFAULT_PAT = 9'b011010101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             overlap,
  input  logic             pat_wr,
  input  logic [LEN-1:0]   pat_data,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(LEN + 1);

  logic [LEN-1:0] hist;
  logic [LEN-1:0] pat;
  logic [FW-1:0]  fill;
  logic [LEN-1:0] shifted;
  logic           accept;
  logic           match;

  // A pattern load owns the cycle, so the bit presented alongside it is dropped.
  assign accept  = en && !pat_wr;
  assign shifted = {hist[LEN-2:0], in};
  assign match   = accept && (fill >= FW'(LEN - 1)) && (shifted == pat);

  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      pat       <= DEFAULT_PAT;
      out       <= 1'b0;
      match_cnt <= '0;
    end else begin
      out <= match;

      if (pat_wr) begin
        pat  <= pat_data;
        fill <= '0;
      end else if (en) begin
        hist <= shifted;
        if (match && !overlap)
          fill <= '0;
        else if (fill != FW'(LEN))
          fill <= fill + FW'(1);
      end

      // Clear wins over the old value but still counts a same-cycle match.
      if (cnt_clr)
        match_cnt <= match ? CNT_W'(1) : '0;
      else if (match && !(&match_cnt))
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed self-checking bench for seq_detect_param
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       in = 1'b0;
  logic       overlap = 1'b1;
  logic       pat_wr = 1'b0;
  logic [8:0] pat_data = '0;
  logic       cnt_clr = 1'b0;
  logic       out, out_s;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt_s;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] dflt = 9'b011010101;
  logic [8:0] alt  = 9'b101010101;
  logic [8:0] cust = 9'b110011100;

  always #5 clk = ~clk;

  seq_detect_param u_dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .overlap(overlap),
    .pat_wr(pat_wr), .pat_data(pat_data), .cnt_clr(cnt_clr),
    .out(out), .match_cnt(match_cnt)
  );

  seq_detect_param #(.LEN(9), .CNT_W(2), .DEFAULT_PAT(9'b011010101)) u_sat (
    .clk(clk), .rst(rst), .en(en), .in(in), .overlap(overlap),
    .pat_wr(pat_wr), .pat_data(pat_data), .cnt_clr(cnt_clr),
    .out(out_s), .match_cnt(match_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    en = 1'b1;
    in = b;
    tick();
    en = 1'b0;
  endtask

  task automatic gap(input int n, input string tag);
    for (int g = 0; g < n; g++) begin
      tick();
      chk(tag, 32'(out), 32'd0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
  endtask

  task automatic load(input logic [8:0] p);
    pat_wr   = 1'b1;
    pat_data = p;
    tick();
    pat_wr   = 1'b0;
  endtask

  initial begin
    // Test 1: default pattern, continuous stream
    overlap = 1'b1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(dflt[8-i]);
      chk("t1_out", 32'(out), (i == 8) ? 32'd1 : 32'd0);
    end
    chk("t1_cnt", 32'(match_cnt), 32'd1);
    gap(1, "t1_after");

    // Test 2: two idle cycles between bits
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(dflt[8-i]);
      chk("t2_out", 32'(out), (i == 8) ? 32'd1 : 32'd0);
      gap(2, "t2_gap");
    end
    chk("t2_cnt", 32'(match_cnt), 32'd1);

    // Test 3: alternating pattern, overlapping then non-overlapping
    do_reset();
    overlap = 1'b1;
    load(alt);
    for (int k = 1; k <= 13; k++) begin
      send((k % 2) == 1);
      chk("t3o_out", 32'(out), (k == 9 || k == 11 || k == 13) ? 32'd1 : 32'd0);
    end
    chk("t3o_cnt", 32'(match_cnt), 32'd3);
    chk("t3o_cnt_s", 32'(match_cnt_s), 32'd3);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t3_clr", 32'(match_cnt), 32'd0);
    overlap = 1'b0;
    load(alt);
    for (int k = 1; k <= 13; k++) begin
      send((k % 2) == 1);
      chk("t3n_out", 32'(out), (k == 9) ? 32'd1 : 32'd0);
    end
    chk("t3n_cnt", 32'(match_cnt), 32'd1);

    // Test 4: pattern load mid-stream drops the bit and restarts fill
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 5; i++) send(dflt[8-i]);
    pat_wr   = 1'b1;
    pat_data = dflt;
    en       = 1'b1;
    in       = dflt[3];
    tick();
    pat_wr   = 1'b0;
    en       = 1'b0;
    chk("t4_wr_out", 32'(out), 32'd0);
    for (int i = 5; i < 9; i++) begin
      send(dflt[8-i]);
      chk("t4_out", 32'(out), 32'd0);
    end
    chk("t4_cnt", 32'(match_cnt), 32'd0);

    // Test 5: saturation on the 2-bit counter, clear with and without a match
    do_reset();
    overlap = 1'b0;
    for (int m = 1; m <= 6; m++) begin
      for (int i = 0; i < 9; i++) begin
        if (m == 6 && i == 8) cnt_clr = 1'b1;
        send(dflt[8-i]);
        cnt_clr = 1'b0;
        chk("t5_out", 32'(out_s), (i == 8) ? 32'd1 : 32'd0);
      end
      if (m < 6) begin
        chk("t5_cnt_s", 32'(match_cnt_s), (m < 3) ? 32'(m) : 32'd3);
        chk("t5_cnt", 32'(match_cnt), 32'(m));
      end
    end
    chk("t5_clrm_s", 32'(match_cnt_s), 32'd1);
    chk("t5_clrm", 32'(match_cnt), 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t5_clr_s", 32'(match_cnt_s), 32'd0);
    chk("t5_clr", 32'(match_cnt), 32'd0);

    // Test 6: reset mid-stream drops history and restores the default pattern
    do_reset();
    overlap = 1'b1;
    load(cust);
    for (int i = 0; i < 8; i++) send(cust[8-i]);
    do_reset();
    send(cust[0]);
    chk("t6_last", 32'(out), 32'd0);
    for (int i = 0; i < 9; i++) begin
      send(dflt[8-i]);
      chk("t6_out", 32'(out), (i == 8) ? 32'd1 : 32'd0);
    end
    chk("t6_cnt", 32'(match_cnt), 32'd1);
    gap(1, "t6_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
